// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the CPU's single-port memory.
// One access per grant: IDLE accept, ACCESS strobe, RESP completion.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              win;
  logic              cmd_we;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              grant0;
  logic              grant1;
  logic              rd_resp;

  // Port 0 wins unless port 1 is also valid and port 0 was granted last
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & ~grant0;

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign busy       = (state != IDLE);

  // RAM data arrives in RESP; pass it through then, hold it afterwards
  assign rd_resp    = (state == RESP) & ~cmd_we;
  assign req0_rdata = (rd_resp & ~win) ? mem_rdata : rdata0_q;
  assign req1_rdata = (rd_resp & win)  ? mem_rdata : rdata1_q;

  // Sequencer FSM with registered memory strobes and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      cmd_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            state  <= ACCESS;
            mem_en <= 1'b1;
            win    <= grant1;
            if (grant1) begin
              mem_we    <= req1_we;
              cmd_we    <= req1_we;
              mem_addr  <= req1_addr;
              mem_wdata <= req1_wdata;
            end else begin
              mem_we    <= req0_we;
              cmd_we    <= req0_we;
              mem_addr  <= req0_addr;
              mem_wdata <= req0_wdata;
            end
          end
        end
        ACCESS: begin
          state     <= RESP;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          req0_done <= ~win;
          req1_done <= win;
        end
        RESP: begin
          state      <= IDLE;
          req0_done  <= 1'b0;
          req1_done  <= 1'b0;
          last_grant <= win;
          if (!cmd_we) begin
            if (win) rdata1_q <= mem_rdata;
            else     rdata0_q <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
